// File: rtl/aeroplane_ctrl_if.sv
// Signal bundle between the aeroplane controller and the video/game logic.
// The controller owns the slave side; the game logic drives the master side.
interface aeroplane_ctrl_if;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       hit;
    logic       restart;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [9:0] plane_x;
    logic [9:0] plane_y;
    logic       aeroplane_gfx;
    logic       alive;
    logic       crashed;

    modport master (
        output frame_tick, btn_left, btn_right, btn_up, btn_down, hit, restart,
        output pixel_x, pixel_y,
        input  plane_x, plane_y, aeroplane_gfx, alive, crashed
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_up, btn_down, hit, restart,
        input  pixel_x, pixel_y,
        output plane_x, plane_y, aeroplane_gfx, alive, crashed
    );
endinterface

// File: rtl/aeroplane_ctrl.sv
// Aeroplane sprite controller: saturating movement, crash blink sequence and restart,
// plus the combinational sprite mask for the current scan pixel.
module aeroplane_ctrl #(
    parameter int unsigned BODY_W       = 10,
    parameter int unsigned BODY_H       = 30,
    parameter int unsigned FLAP_W       = 25,
    parameter int unsigned FLAP_H       = 5,
    parameter int unsigned START_X      = 13,
    parameter int unsigned START_Y      = 400,
    parameter int unsigned STEP         = 4,
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned CRASH_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input logic             clk,
    input logic             reset,
    aeroplane_ctrl_if.slave bus
);

    localparam logic [1:0] ST_FLY   = 2'd0;
    localparam logic [1:0] ST_CRASH = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;

    localparam int unsigned CNT_W = $clog2(CRASH_FRAMES + 1);
    localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [10:0] STEP_11  = 11'(STEP);
    localparam logic [10:0] MAX_X_11 = 11'(SCREEN_W - FLAP_W);
    localparam logic [10:0] MAX_Y_11 = 11'(SCREEN_H - BODY_H);
    localparam logic [10:0] FUS_DX   = 11'((FLAP_W - BODY_W) / 2);
    localparam logic [10:0] WING_DY  = 11'((BODY_H - FLAP_H) / 2);

    logic [1:0]       r_state, w_state_d;
    logic [9:0]       r_x, w_x_d;
    logic [9:0]       r_y, w_y_d;
    logic [CNT_W-1:0] r_crash_cnt, w_crash_cnt_d;
    logic [BLK_W-1:0] r_blink_cnt, w_blink_cnt_d;
    logic             r_blink, w_blink_d;

    logic [10:0] w_x_ext, w_y_ext, w_x_sum, w_y_sum;
    logic [9:0]  w_x_inc, w_x_dec, w_y_inc, w_y_dec;
    logic        w_mv_left, w_mv_right, w_mv_up, w_mv_down;

    assign w_x_ext = {1'b0, r_x};
    assign w_y_ext = {1'b0, r_y};
    assign w_x_sum = w_x_ext + STEP_11;
    assign w_y_sum = w_y_ext + STEP_11;

    // Saturate in 11 bits so neither direction can wrap.
    assign w_x_inc = (w_x_sum > MAX_X_11) ? MAX_X_11[9:0] : w_x_sum[9:0];
    assign w_y_inc = (w_y_sum > MAX_Y_11) ? MAX_Y_11[9:0] : w_y_sum[9:0];
    assign w_x_dec = (w_x_ext < STEP_11) ? 10'd0 : r_x - STEP_11[9:0];
    assign w_y_dec = (w_y_ext < STEP_11) ? 10'd0 : r_y - STEP_11[9:0];

    assign w_mv_left  = bus.btn_left  & ~bus.btn_right;
    assign w_mv_right = bus.btn_right & ~bus.btn_left;
    assign w_mv_up    = bus.btn_up    & ~bus.btn_down;
    assign w_mv_down  = bus.btn_down  & ~bus.btn_up;

    always_comb begin
        w_state_d     = r_state;
        w_x_d         = r_x;
        w_y_d         = r_y;
        w_crash_cnt_d = r_crash_cnt;
        w_blink_cnt_d = r_blink_cnt;
        w_blink_d     = r_blink;
        case (r_state)
            ST_FLY: begin
                if (bus.hit) begin
                    w_state_d     = ST_CRASH;
                    w_crash_cnt_d = '0;
                    w_blink_cnt_d = '0;
                    w_blink_d     = 1'b0;
                end else if (bus.frame_tick) begin
                    if (w_mv_left)  w_x_d = w_x_dec;
                    if (w_mv_right) w_x_d = w_x_inc;
                    if (w_mv_up)    w_y_d = w_y_dec;
                    if (w_mv_down)  w_y_d = w_y_inc;
                end
            end
            ST_CRASH: begin
                if (bus.frame_tick) begin
                    w_crash_cnt_d = r_crash_cnt + 1'b1;
                    if (r_crash_cnt == CNT_W'(CRASH_FRAMES - 1)) w_state_d = ST_DEAD;
                    if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                        w_blink_cnt_d = '0;
                        w_blink_d     = ~r_blink;
                    end else begin
                        w_blink_cnt_d = r_blink_cnt + 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                if (bus.restart) begin
                    w_state_d     = ST_FLY;
                    w_x_d         = 10'(START_X);
                    w_y_d         = 10'(START_Y);
                    w_crash_cnt_d = '0;
                    w_blink_cnt_d = '0;
                    w_blink_d     = 1'b0;
                end
            end
            default: w_state_d = ST_FLY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_FLY;
            r_x         <= 10'(START_X);
            r_y         <= 10'(START_Y);
            r_crash_cnt <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_x         <= w_x_d;
            r_y         <= w_y_d;
            r_crash_cnt <= w_crash_cnt_d;
            r_blink_cnt <= w_blink_cnt_d;
            r_blink     <= w_blink_d;
        end
    end

    logic [10:0] w_px, w_py, w_fus_x, w_wing_y;
    logic        w_in_fus, w_in_wing, w_shape;

    assign w_px     = {1'b0, bus.pixel_x};
    assign w_py     = {1'b0, bus.pixel_y};
    assign w_fus_x  = w_x_ext + FUS_DX;
    assign w_wing_y = w_y_ext + WING_DY;

    assign w_in_fus  = (w_px >= w_fus_x) && (w_px < w_fus_x + 11'(BODY_W)) &&
                       (w_py >= w_y_ext) && (w_py < w_y_ext + 11'(BODY_H));
    assign w_in_wing = (w_px >= w_x_ext) && (w_px < w_x_ext + 11'(FLAP_W)) &&
                       (w_py >= w_wing_y) && (w_py < w_wing_y + 11'(FLAP_H));
    assign w_shape   = w_in_fus | w_in_wing;

    assign bus.aeroplane_gfx = (r_state == ST_FLY) ? w_shape :
                               (r_state == ST_CRASH) ? (w_shape & ~r_blink) : 1'b0;
    assign bus.plane_x = r_x;
    assign bus.plane_y = r_y;
    assign bus.alive   = (r_state == ST_FLY);
    assign bus.crashed = (r_state == ST_CRASH) || (r_state == ST_DEAD);

endmodule
